// File: rtl/fmap_fifo_pkg.sv
// -----------------------------------------------------------------------------
// fmap_fifo_pkg
// Shared definitions for the feature-map replay FIFO:
//   - default geometry (8-bit pixels, 150 entries)
//   - width helpers used to derive pointer / counter widths from DEPTH
//   - ptr_inc: pointer increment that wraps at DEPTH-1 (DEPTH need not be
//     a power of two, so no bit masking is used)
// -----------------------------------------------------------------------------
package fmap_fifo_pkg;

    localparam int unsigned FMAP_DEF_DATA_W = 8;
    localparam int unsigned FMAP_DEF_DEPTH  = 150;

    // Address width for a memory of 'depth' entries (never below 1 bit).
    function automatic int unsigned fmap_ptr_w(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned fmap_cnt_w(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

    // Increment a pointer, wrapping depth-1 back to 0.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
        logic [31:0] nxt;
        if (ptr == (depth - 32'd1)) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fmap_fifo_mem.sv
// -----------------------------------------------------------------------------
// fmap_fifo_mem
// Simple dual-port RAM, DATA_W x DEPTH, synchronous write, registered read.
// The storage array has no reset; only the read-data register is reset so the
// FIFO output starts at zero.
// Ports:
//   clk      clock (rising edge)
//   rstn     async active-low reset of the read-data register
//   wr_en    write strobe
//   wr_addr  write address (0..DEPTH-1)
//   wr_data  write data
//   rd_en    read strobe; rd_data updates only when set
//   rd_addr  read address (0..DEPTH-1)
//   rd_data  registered read data, holds when rd_en is low
// -----------------------------------------------------------------------------
module fmap_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 150,
    parameter int unsigned PTR_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds the last word when not reading.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/fmap_replay_fifo.sv
// -----------------------------------------------------------------------------
// fmap_replay_fifo
// Feature-map line FIFO with window replay. Entries between base_ptr and
// wr_ptr are "retained"; entries between rd_ptr and wr_ptr are "unread".
// rd_rewind moves the read pointer back to the oldest retained entry so the
// PE array can re-read the same window; rd_release hands every entry read so
// far back to the writer.
//
// Optional feature macro: FMAP_FIFO_STATUS_EN adds level / ovf_err / udf_err.
//
// Ports:
//   clk, rstn    clock, async active-low reset
//   din, wr_en   write data / request (accepted when !full)
//   rd_en        read request (accepted when !empty and no effective rewind)
//   rd_rewind    rd_ptr <= base_ptr (ignored if rd_release is also set)
//   rd_release   base_ptr <= read pointer after any same-cycle read
//   dout         registered read data (holds between reads)
//   dout_valid   one-cycle pulse, dout holds a newly read word
//   full, empty  from registered retained / unread counts
//   level        retained count                  [FMAP_FIFO_STATUS_EN]
//   ovf_err      sticky, wr_en seen while full   [FMAP_FIFO_STATUS_EN]
//   udf_err      sticky, rd_en seen while empty  [FMAP_FIFO_STATUS_EN]
// -----------------------------------------------------------------------------
module fmap_replay_fifo
    import fmap_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FMAP_DEF_DATA_W,
    parameter int unsigned DEPTH  = FMAP_DEF_DEPTH,
    parameter int unsigned PTR_W  = fmap_ptr_w(DEPTH),
    parameter int unsigned CNT_W  = fmap_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              rd_rewind,
    input  logic              rd_release,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty
`ifdef FMAP_FIFO_STATUS_EN
    ,
    output logic [CNT_W-1:0]  level,
    output logic              ovf_err,
    output logic              udf_err
`endif
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};

    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, base_ptr_r;
    logic [CNT_W-1:0] ret_cnt_r, unrd_cnt_r;
    logic             dout_valid_r;

    logic             full_s, empty_s;
    logic             wr_acc_s, rd_acc_s, rewind_s;
    logic [PTR_W-1:0] wr_ptr_inc_s, rd_ptr_inc_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s, base_ptr_nxt_s;
    logic [CNT_W-1:0] wr_add_s, rd_sub_s;
    logic [CNT_W-1:0] ret_cnt_nxt_s, unrd_cnt_nxt_s;

    assign wr_ptr_inc_s = PTR_W'(ptr_inc(32'(wr_ptr_r), 32'(DEPTH)));
    assign rd_ptr_inc_s = PTR_W'(ptr_inc(32'(rd_ptr_r), 32'(DEPTH)));

    // Handshake qualification and next-state of pointers and counters.
    // Flags come from the registered counts, so space freed by a release
    // is only visible to the writer on the following cycle.
    always_comb begin
        full_s         = (ret_cnt_r == DEPTH_CNT);
        empty_s        = (unrd_cnt_r == CNT_ZERO);
        wr_acc_s       = wr_en && !full_s;
        // Release has priority: a rewind issued together with it is dropped.
        rewind_s       = rd_rewind && !rd_release;
        rd_acc_s       = rd_en && !empty_s && !rewind_s;
        wr_add_s       = wr_acc_s ? CNT_ONE : CNT_ZERO;
        rd_sub_s       = rd_acc_s ? CNT_ONE : CNT_ZERO;

        wr_ptr_nxt_s   = wr_acc_s ? wr_ptr_inc_s : wr_ptr_r;

        if (rewind_s) begin
            rd_ptr_nxt_s   = base_ptr_r;
            // Every retained entry becomes unread again, including a new write.
            unrd_cnt_nxt_s = ret_cnt_r + wr_add_s;
        end else if (rd_acc_s) begin
            rd_ptr_nxt_s   = rd_ptr_inc_s;
            unrd_cnt_nxt_s = unrd_cnt_r + wr_add_s - rd_sub_s;
        end else begin
            rd_ptr_nxt_s   = rd_ptr_r;
            unrd_cnt_nxt_s = unrd_cnt_r + wr_add_s;
        end

        if (rd_release) begin
            // Only the not-yet-read entries stay retained.
            base_ptr_nxt_s = rd_ptr_nxt_s;
            ret_cnt_nxt_s  = unrd_cnt_nxt_s;
        end else begin
            base_ptr_nxt_s = base_ptr_r;
            ret_cnt_nxt_s  = ret_cnt_r + wr_add_s;
        end
    end

    // Pointer, counter and read-valid registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            base_ptr_r   <= PTR_ZERO;
            ret_cnt_r    <= CNT_ZERO;
            unrd_cnt_r   <= CNT_ZERO;
            dout_valid_r <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            base_ptr_r   <= base_ptr_nxt_s;
            ret_cnt_r    <= ret_cnt_nxt_s;
            unrd_cnt_r   <= unrd_cnt_nxt_s;
            dout_valid_r <= rd_acc_s;
        end
    end

    fmap_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_r),
        .wr_data (din),
        .rd_en   (rd_acc_s),
        .rd_addr (rd_ptr_r),
        .rd_data (dout)
    );

    assign dout_valid = dout_valid_r;
    assign full       = full_s;
    assign empty      = empty_s;

`ifdef FMAP_FIFO_STATUS_EN
    logic ovf_err_r, udf_err_r;

    // Sticky protocol-error flags; only reset clears them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_err_r <= 1'b0;
            udf_err_r <= 1'b0;
        end else begin
            ovf_err_r <= ovf_err_r | (wr_en & full_s);
            udf_err_r <= udf_err_r | (rd_en & empty_s);
        end
    end

    assign level   = ret_cnt_r;
    assign ovf_err = ovf_err_r;
    assign udf_err = udf_err_r;
`endif

endmodule

// File: tb/tb_fmap_replay_fifo.sv
// -----------------------------------------------------------------------------
// tb_fmap_replay_fifo
// Two instances (8b x 150 and 16b x 7) share one stimulus stream. A retained-
// window list model (plain list of retained words plus a read index) predicts
// every output each cycle; a constant vector table and directed sequences
// cover replay, release and simultaneous-control corner cases.
// -----------------------------------------------------------------------------
module tb_fmap_replay_fifo;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] din = 16'd0;
    logic        wr_en = 1'b0, rd_en = 1'b0, rd_rewind = 1'b0, rd_release = 1'b0;

    logic [7:0]  a_dout;
    logic [15:0] b_dout;
    logic        a_dv, b_dv, a_full, b_full, a_empty, b_empty;
`ifdef FMAP_FIFO_STATUS_EN
    logic [7:0]  a_level;
    logic [2:0]  b_level;
    logic        a_ovf, b_ovf, a_udf, b_udf;
`endif

    always #5 clk = ~clk;

    fmap_replay_fifo #(.DATA_W(8), .DEPTH(150)) u_a (
        .clk(clk), .rstn(rstn), .din(din[7:0]), .wr_en(wr_en), .rd_en(rd_en),
        .rd_rewind(rd_rewind), .rd_release(rd_release), .dout(a_dout),
        .dout_valid(a_dv), .full(a_full), .empty(a_empty)
`ifdef FMAP_FIFO_STATUS_EN
        , .level(a_level), .ovf_err(a_ovf), .udf_err(a_udf)
`endif
    );

    fmap_replay_fifo #(.DATA_W(16), .DEPTH(7)) u_b (
        .clk(clk), .rstn(rstn), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .rd_rewind(rd_rewind), .rd_release(rd_release), .dout(b_dout),
        .dout_valid(b_dv), .full(b_full), .empty(b_empty)
`ifdef FMAP_FIFO_STATUS_EN
        , .level(b_level), .ovf_err(b_ovf), .udf_err(b_udf)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per instance, the retained words in age order and how
    // many of them have been read since the last rewind/release.
    int unsigned m_ret   [2][150];
    int          m_n     [2];
    int          m_r     [2];
    int unsigned m_dout  [2];
    int          m_dv    [2];
    int          m_ovf   [2];
    int          m_udf   [2];
    int          m_depth [2] = '{150, 7};
    int unsigned m_mask  [2] = '{32'h00ff, 32'hffff};

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; m_r[k] = 0; m_dout[k] = 0; m_dv[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        bit f, e, wa, rw, ra;
        f  = (m_n[k] == m_depth[k]);
        e  = (m_n[k] == m_r[k]);
        wa = wr_en && !f;
        rw = rd_rewind && !rd_release;
        ra = rd_en && !e && !rw;
        if (wr_en && f) m_ovf[k] = 1;
        if (rd_en && e) m_udf[k] = 1;
        m_dv[k] = ra ? 1 : 0;
        if (ra) begin
            m_dout[k] = m_ret[k][m_r[k]];
            m_r[k]++;
        end
        if (rw) m_r[k] = 0;
        if (wa) begin
            m_ret[k][m_n[k]] = din & m_mask[k];
            m_n[k]++;
        end
        if (rd_release) begin
            for (int i = 0; i < m_n[k] - m_r[k]; i++) m_ret[k][i] = m_ret[k][i + m_r[k]];
            m_n[k] = m_n[k] - m_r[k];
            m_r[k] = 0;
        end
    endtask

    task automatic compare_all();
        chk("a_dout_valid", a_dv, m_dv[0]);
        chk("a_dout", a_dout, m_dout[0]);
        chk("a_full", a_full, (m_n[0] == m_depth[0]) ? 1 : 0);
        chk("a_empty", a_empty, (m_n[0] == m_r[0]) ? 1 : 0);
        chk("b_dout_valid", b_dv, m_dv[1]);
        chk("b_dout", b_dout, m_dout[1]);
        chk("b_full", b_full, (m_n[1] == m_depth[1]) ? 1 : 0);
        chk("b_empty", b_empty, (m_n[1] == m_r[1]) ? 1 : 0);
`ifdef FMAP_FIFO_STATUS_EN
        chk("a_level", a_level, m_n[0]);
        chk("b_level", b_level, m_n[1]);
        chk("a_ovf_err", a_ovf, m_ovf[0]);
        chk("b_ovf_err", b_ovf, m_ovf[1]);
        chk("a_udf_err", a_udf, m_udf[0]);
        chk("b_udf_err", b_udf, m_udf[1]);
`endif
    endtask

    // One clock: drive at negedge, step the model, compare at next negedge.
    task automatic cycle(input bit w, input logic [15:0] d, input bit r, input bit rw, input bit rl);
        wr_en = w; din = d; rd_en = r; rd_rewind = rw; rd_release = rl;
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Reset held low for one cycle; outputs checked while still in reset.
    task automatic do_reset();
        wr_en = 1'b0; rd_en = 1'b0; rd_rewind = 1'b0; rd_release = 1'b0;
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rstn = 1'b1;
    endtask

    typedef struct {
        bit          w;
        logic [15:0] d;
        bit          r;
        bit          rw;
        bit          rl;
        bit          e_dv;
        logic [15:0] e_dout;
        bit          e_empty;
    } vec_t;

    vec_t vt [12];

    initial begin
        // Constant vectors, applied from reset (neither instance reaches full).
        vt[0]  = '{1, 16'h0011, 0, 0, 0, 0, 16'h0000, 0};  // first write
        vt[1]  = '{1, 16'h0022, 1, 0, 0, 1, 16'h0011, 0};  // write + read
        vt[2]  = '{0, 16'h0000, 1, 0, 0, 1, 16'h0022, 1};  // drain last unread
        vt[3]  = '{0, 16'h0000, 1, 0, 0, 0, 16'h0022, 1};  // read while empty
        vt[4]  = '{0, 16'h0000, 0, 1, 0, 0, 16'h0022, 0};  // rewind: 2 unread again
        vt[5]  = '{0, 16'h0000, 1, 0, 0, 1, 16'h0011, 0};  // replay oldest
        vt[6]  = '{0, 16'h0000, 1, 1, 0, 0, 16'h0011, 0};  // read + rewind: no read
        vt[7]  = '{0, 16'h0000, 1, 0, 0, 1, 16'h0011, 0};  // back at base
        vt[8]  = '{0, 16'h0000, 0, 0, 1, 0, 16'h0011, 0};  // release 1 consumed
        vt[9]  = '{0, 16'h0000, 1, 1, 1, 1, 16'h0022, 1};  // release beats rewind
        vt[10] = '{1, 16'h0033, 1, 0, 0, 0, 16'h0022, 0};  // write to empty, read refused
        vt[11] = '{1, 16'h0044, 1, 0, 0, 1, 16'h0033, 0};  // readable next cycle

        @(negedge clk);
        do_reset();

        // Reset mid-stream.
        for (int i = 1; i <= 5; i++) cycle(1, 16'(i), 0, 0, 0);
        do_reset();

        // Constant table.
        for (int i = 0; i < 12; i++) begin
            cycle(vt[i].w, vt[i].d, vt[i].r, vt[i].rw, vt[i].rl);
            chk("tbl_a_dv", a_dv, vt[i].e_dv);
            chk("tbl_a_dout", a_dout, vt[i].e_dout & 16'h00ff);
            chk("tbl_a_empty", a_empty, vt[i].e_empty);
            chk("tbl_b_dv", b_dv, vt[i].e_dv);
            chk("tbl_b_dout", b_dout, vt[i].e_dout);
            chk("tbl_b_empty", b_empty, vt[i].e_empty);
        end

        // Fill / drain (B sees the same stream at depth 7).
        do_reset();
        for (int i = 0; i < 150; i++) cycle(1, 16'(i), 0, 0, 0);
        chk("fill_a_full", a_full, 1);
        cycle(1, 16'd999, 0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            cycle(0, 16'd0, 1, 0, 0);
            chk("drain_a_dout", a_dout, i);
        end
        cycle(0, 16'd0, 1, 0, 0);

        // Replay window twice.
        do_reset();
        for (int i = 1; i <= 9; i++) cycle(1, 16'(i), 0, 0, 0);
        for (int p = 0; p < 2; p++) begin
            for (int i = 1; i <= 9; i++) begin
                cycle(0, 16'd0, 1, 0, 0);
                chk("replay_a_dout", a_dout, i);
            end
            cycle(0, 16'd0, 0, 1, 0);
        end
        chk("replay_a_full", a_full, 0);

        // Release frees space; writer wraps around.
        do_reset();
        for (int i = 0; i < 150; i++) cycle(1, 16'(i + 300), 0, 0, 0);
        for (int i = 0; i < 50; i++) cycle(0, 16'd0, 1, 0, 0);
        cycle(0, 16'd0, 0, 0, 1);
        chk("release_a_full", a_full, 0);
        for (int i = 0; i < 50; i++) cycle(1, 16'(i + 1000), 0, 0, 0);
        chk("refill_a_full", a_full, 1);
        for (int i = 0; i < 150; i++) cycle(0, 16'd0, 1, 0, 0);

        // Write + read with one entry held.
        do_reset();
        cycle(1, 16'h0abc, 0, 0, 0);
        cycle(1, 16'h0def, 1, 0, 0);
        chk("wr_rd_a_dout", a_dout, 32'h00bc);

        // Randomised traffic.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 99) < 55), 16'($urandom),
                      ($urandom_range(0, 99) < 50),
                      ($urandom_range(0, 99) < 4),
                      ($urandom_range(0, 99) < 6));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
